arm_multicycle_ctrl: RTL and testbench

//  Multicycle control FSM for the ARM-subset processor. Sequences a shared-memory multicycle datapath
//  (IR, ALUOut, Data regs) through fetch/decode/execute/writeback. Decodes Op/Funct/Rd, evaluates

---
 rtl/arm_multicycle_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_arm_multicycle_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// arm_multicycle_ctrl
// Control FSM for the multicycle ARM-subset processor. Sequences the shared
// memory datapath through fetch / decode / execute / writeback, decodes the
// data-processing command, evaluates the condition field against an internal
// NZCV register and gates every architectural write with the condition result.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   Cond/Op/Funct/Rd  instruction fields from the IR
//   ALUFlags          live NZCV from the ALU
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
//   ALUSrcB, ALUControl, ImmSrc, RegSrc
//                     datapath enables / selects, decoded from the current
//                     state so they act in the same cycle the state is held
// ---------------------------------------------------------------------------
module arm_multicycle_ctrl #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc
);

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CMD_W  = 4;

  localparam logic [3:0] PC_REG = 4'd15;

  localparam logic [SEL_W-1:0] OP_DP  = 2'b00;
  localparam logic [SEL_W-1:0] OP_MEM = 2'b01;
  localparam logic [SEL_W-1:0] OP_BR  = 2'b10;

  localparam logic [SEL_W-1:0] ALU_ADD = 2'b00;
  localparam logic [SEL_W-1:0] ALU_SUB = 2'b01;
  localparam logic [SEL_W-1:0] ALU_AND = 2'b10;
  localparam logic [SEL_W-1:0] ALU_ORR = 2'b11;

  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_WD   = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_e;

  // Which flag bits an S-suffixed data-processing op may update
  typedef enum logic [1:0] {
    FUPD_NONE,
    FUPD_NZ,
    FUPD_NZCV
  } fupd_e;

  state_e              state_q, state_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                cond_ex_q, cond_ex_d;

  logic [CMD_W-1:0]    cmd;
  logic [SEL_W-1:0]    dp_alu_ctrl;
  logic                dp_wb;
  fupd_e               dp_fupd;
  logic                cond_pass;
  logic                flag_n, flag_z, flag_c, flag_v;
  logic                rd_is_pc;

  assign cmd      = Funct[4:1];
  assign rd_is_pc = (Rd == PC_REG);
  assign flag_n   = flags_q[3];
  assign flag_z   = flags_q[2];
  assign flag_c   = flags_q[1];
  assign flag_v   = flags_q[0];

  // Data-processing command decode; unknown commands run as a silent ADD
  always_comb begin
    dp_alu_ctrl = ALU_ADD;
    dp_wb       = 1'b0;
    dp_fupd     = FUPD_NONE;
    unique case (cmd)
      4'b0100: begin dp_alu_ctrl = ALU_ADD; dp_wb = 1'b1; dp_fupd = FUPD_NZCV; end
      4'b0010: begin dp_alu_ctrl = ALU_SUB; dp_wb = 1'b1; dp_fupd = FUPD_NZCV; end
      4'b0000: begin dp_alu_ctrl = ALU_AND; dp_wb = 1'b1; dp_fupd = FUPD_NZ;   end
      4'b1100: begin dp_alu_ctrl = ALU_ORR; dp_wb = 1'b1; dp_fupd = FUPD_NZ;   end
      4'b1010: begin dp_alu_ctrl = ALU_SUB; dp_wb = 1'b0; dp_fupd = FUPD_NZCV; end
      default: begin dp_alu_ctrl = ALU_ADD; dp_wb = 1'b0; dp_fupd = FUPD_NONE; end
    endcase
  end

  // ARM condition-field evaluation against the stored flags
  always_comb begin
    cond_pass = 1'b0;
    unique case (Cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // State, flag and condition registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      flags_q   <= RESET_FLAGS;
      cond_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  // Next-state, flag update and per-state datapath controls
  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    cond_ex_d  = cond_ex_q;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_WD;
    ALUControl = ALU_ADD;
    ImmSrc     = Op;
    RegSrc     = {(Op == OP_MEM), (Op == OP_BR)};

    unique case (state_q)
      S_FETCH: begin
        // PC+4 is written back unconditionally while the IR loads
        AdrSrc    = 1'b0;
        IRWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        PCWrite   = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        cond_ex_d = cond_pass;
        unique case (Op)
          OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b0;
        ALUSrcB = SRCB_IMM;
        state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = cond_ex_q & ~rd_is_pc;
        PCWrite   = cond_ex_q & rd_is_pc;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex_q;
        state_d  = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA    = 1'b0;
        ALUSrcB    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_WD;
        ALUControl = dp_alu_ctrl;
        // Flags are taken from this cycle's ALU result
        if (Funct[0] && cond_ex_q) begin
          unique case (dp_fupd)
            FUPD_NZCV: flags_d = ALUFlags;
            FUPD_NZ:   flags_d = {ALUFlags[3:2], flags_q[1:0]};
            default:   flags_d = flags_q;
          endcase
        end
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = cond_ex_q & dp_wb & ~rd_is_pc;
        PCWrite   = cond_ex_q & dp_wb & rd_is_pc;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        PCWrite   = cond_ex_q;
        state_d   = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Reset forces every strobe and select low
    if (reset) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = '0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = '0;
      ALUControl = '0;
      ImmSrc     = '0;
      RegSrc     = '0;
    end
  end

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_arm_multicycle_ctrl
// Scoreboard bench: each instruction pushes its expected per-cycle control
// vector sequence, derived from a small ISA-level model with its own NZCV
// copy; a negedge monitor pops and compares against the DUT outputs.
// Vector = {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,
//           ALUSrcB,ALUControl,ImmSrc,RegSrc}
// ---------------------------------------------------------------------------
module tb_arm_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;

  arm_multicycle_ctrl #(.RESET_FLAGS(4'b0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .Cond       (Cond),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] obs_vec;
  assign obs_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                    ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];
  logic [3:0]  m_flags;   // model NZCV

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic sa, input logic [1:0] sb,
                                     input logic [1:0] ac, input logic [1:0] op);
    logic rs_hi, rs_lo;
    rs_hi = (op == 2'b01);
    rs_lo = (op == 2'b10);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, ac, op, rs_hi, rs_lo};
  endfunction

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input string tag, input logic [15:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  // Monitor: compare one expected vector per cycle, mid-cycle
  always @(negedge clk) begin : mon
    logic [15:0] e;
    string       t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, 32'(obs_vec), 32'(e));
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one instruction from FETCH, queue its expected cycles, run it
  task automatic run_instr(input string name, input logic [3:0] c, input logic [1:0] op,
                           input logic [5:0] f, input logic [3:0] rd, input logic [3:0] af);
    int         ncyc;
    logic       ce, wb, pc;
    logic [1:0] alu;
    int         fm;
    Cond = c; Op = op; Funct = f; Rd = rd; ALUFlags = af;
    ce   = cond_ok(c, m_flags);
    pc   = (rd == 4'd15);
    ncyc = 2;
    push({name, ":FETCH"},  mk(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 2'b00, op));
    push({name, ":DECODE"}, mk(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, op));
    case (op)
      2'b01: begin
        push({name, ":MEMADR"}, mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, op));
        if (f[0]) begin
          push({name, ":MEMREAD"}, mk(0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, op));
          push({name, ":MEMWB"},   mk(ce && pc, 0, 0, 0, ce && !pc, 2'b01, 0, 2'b00, 2'b00, op));
          ncyc += 3;
        end else begin
          push({name, ":MEMWRITE"}, mk(0, 1, ce, 0, 0, 2'b00, 0, 2'b00, 2'b00, op));
          ncyc += 2;
        end
      end
      2'b00: begin
        case (f[4:1])
          4'b0100: begin alu = 2'b00; wb = 1; fm = 2; end
          4'b0010: begin alu = 2'b01; wb = 1; fm = 2; end
          4'b0000: begin alu = 2'b10; wb = 1; fm = 1; end
          4'b1100: begin alu = 2'b11; wb = 1; fm = 1; end
          4'b1010: begin alu = 2'b01; wb = 0; fm = 2; end
          default: begin alu = 2'b00; wb = 0; fm = 0; end
        endcase
        push({name, ":EXEC"}, mk(0, 0, 0, 0, 0, 2'b00, 0, f[5] ? 2'b01 : 2'b00, alu, op));
        push({name, ":ALUWB"}, mk(ce && wb && pc, 0, 0, 0, ce && wb && !pc, 2'b00, 0, 2'b00, 2'b00, op));
        ncyc += 2;
        if (f[0] && ce) begin
          if (fm == 2)      m_flags = af;
          else if (fm == 1) m_flags = {af[3:2], m_flags[1:0]};
        end
      end
      2'b10: begin
        push({name, ":BRANCH"}, mk(ce, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, op));
        ncyc += 1;
      end
      default: ;
    endcase
    wait_cycles(ncyc);
  endtask

  initial begin
    reset = 1'b1; Cond = 4'h0; Op = 2'b00; Funct = 6'h0; Rd = 4'h0; ALUFlags = 4'h0;
    m_flags = 4'b0000;
    @(posedge clk); #1;

    // Reset held: every strobe and select low
    for (int i = 0; i < 3; i++) push("reset_hold", 16'h0000);
    wait_cycles(3);
    reset = 1'b0;

    run_instr("ADD_r1",   4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000);
    run_instr("SUBS_r0",  4'hE, 2'b00, 6'b100101, 4'd0, 4'b0100);
    run_instr("BNE",      4'h1, 2'b10, 6'b101111, 4'd0, 4'b0000);
    run_instr("BEQ",      4'h0, 2'b10, 6'b101111, 4'd0, 4'b0000);
    run_instr("LDR_r4",   4'hE, 2'b01, 6'b011001, 4'd4, 4'b0000);
    run_instr("STR_r4",   4'hE, 2'b01, 6'b011000, 4'd4, 4'b0000);
    run_instr("LDR_pc",   4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000);
    run_instr("CMP_cv",   4'hE, 2'b00, 6'b010101, 4'd0, 4'b0011);
    run_instr("ANDS_z",   4'hE, 2'b00, 6'b000001, 4'd5, 4'b0100);
    run_instr("ADDCS",    4'h2, 2'b00, 6'b001000, 4'd6, 4'b0000);
    run_instr("ADDVS",    4'h6, 2'b00, 6'b001000, 4'd6, 4'b0000);
    run_instr("ADDEQ",    4'h0, 2'b00, 6'b001000, 4'd6, 4'b0000);
    run_instr("ADDMI",    4'h4, 2'b00, 6'b001000, 4'd6, 4'b0000);
    run_instr("ADDHI",    4'h8, 2'b00, 6'b001000, 4'd6, 4'b0000);
    run_instr("ADDLS",    4'h9, 2'b00, 6'b001000, 4'd6, 4'b0000);
    run_instr("STRNE",    4'h1, 2'b01, 6'b011000, 4'd2, 4'b0000);
    run_instr("CMP_eq",   4'hE, 2'b00, 6'b010101, 4'd0, 4'b0110);
    run_instr("ADDEQ2",   4'h0, 2'b00, 6'b001000, 4'd3, 4'b0000);
    run_instr("ADDNE",    4'h1, 2'b00, 6'b001000, 4'd3, 4'b0000);
    run_instr("ADD_nv",   4'hF, 2'b00, 6'b001000, 4'd1, 4'b0000);
    run_instr("STR_nv",   4'hF, 2'b01, 6'b011000, 4'd1, 4'b0000);
    run_instr("OP11",     4'hE, 2'b11, 6'b111111, 4'd1, 4'b0000);
    run_instr("ADD_pc",   4'hE, 2'b00, 6'b001000, 4'd15, 4'b0000);
    run_instr("ORR_imm",  4'hE, 2'b00, 6'b111000, 4'd7, 4'b1000);
    run_instr("SUB_reg",  4'hE, 2'b00, 6'b000100, 4'd8, 4'b0000);
    run_instr("ORRS_n",   4'hE, 2'b00, 6'b011001, 4'd9, 4'b1011);
    run_instr("ADDMI2",   4'h4, 2'b00, 6'b001000, 4'd6, 4'b0000);
    run_instr("ADDCS2",   4'h2, 2'b00, 6'b001000, 4'd6, 4'b0000);
    run_instr("CMP_eq2",  4'hE, 2'b00, 6'b010101, 4'd0, 4'b0110);

    // Reset in MEMREAD aborts the load and clears flags/condition
    Cond = 4'hE; Op = 2'b01; Funct = 6'b011001; Rd = 4'd4; ALUFlags = 4'h0;
    push("abort:FETCH",  mk(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 2'b00, 2'b01));
    push("abort:DECODE", mk(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b01));
    push("abort:MEMADR", mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b01));
    wait_cycles(3);
    reset = 1'b1;
    push("abort:reset", 16'h0000);
    wait_cycles(1);
    reset   = 1'b0;
    m_flags = 4'b0000;
    run_instr("post_EQ",  4'h0, 2'b00, 6'b001000, 4'd2, 4'b0000);
    run_instr("post_NE",  4'h1, 2'b00, 6'b001000, 4'd2, 4'b0000);

    // Random instruction mix; unknown commands never set S
    for (int i = 0; i < 40; i++) begin
      logic [3:0] rc, rr, ra;
      logic [1:0] ro;
      logic [5:0] rf;
      rc = 4'($urandom_range(0, 15));
      ro = 2'($urandom_range(0, 3));
      rf = 6'($urandom_range(0, 63));
      rr = 4'($urandom_range(0, 15));
      ra = 4'($urandom_range(0, 15));
      if (ro == 2'b00 && !(rf[4:1] inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010}))
        rf[0] = 1'b0;
      run_instr($sformatf("rnd%0d", i), rc, ro, rf, rr, ra);
    end

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
